pwm_ramp_ctrl: RTL and testbench
================================

PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 SHALL have parameter W, default 7: duty/compare width, matching the 7-bit timer and compare path.
REQ-002 SHALL have parameter DIVW, default 4: width of the ramp-rate divider.
REQ-003 SHALL have port CLK  in  1  system clock; all state changes on posedge.
REQ-004 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port EN  in  1  run request; 0 ramps duty down to 0.
REQ-006 SHALL have port TARGET  in  W  requested duty (compare value), unsigned.
REQ-007 SHALL have port STEP  in  3  duty increment per ramp step; value 0 is treated as 1.
REQ-008 SHALL have port DIV  in  DIVW  PWM periods per ramp step, minus 1.
REQ-009 SHALL have port PERIOD_E  in  1  one-CLK pulse at PWM period start (timer wrap 7F->00).
REQ-010 SHALL have port FAULT_IN  in  1  fault request, level-sensitive, highest priority.
REQ-011 SHALL have port FAULT_CLR  in  1  fault acknowledge.
REQ-012 SHALL have port DUTY  out  W  registered compare value fed to the PWM compare register.
REQ-013 SHALL have port DUTY_LD  out  1  one-CLK pulse coincident with each DUTY update.
REQ-014 SHALL have port AT_TARGET  out  1  high in HOLD only.
REQ-015 SHALL have port STATE  out  2  IDLE=00, RAMP=01, HOLD=10, FAULT=11.
REQ-016 SHALL have port FAULT  out  1  high in FAULT only.

Function
REQ-017 SHALL define the effective target as TGT = EN ? TARGET : 0, sampled each CLK edge.
REQ-018 SHALL, in IDLE with DUTY=0: go to RAMP on the edge where TGT!=0; otherwise stay in IDLE.
REQ-019 SHALL, in RAMP, act only on edges with PERIOD_E=1: if div_cnt<DIV, increment div_cnt; else clear div_cnt and take one step.
REQ-020 SHALL compute a step as DUTY += min(STEP_eff, TGT-DUTY) when TGT>DUTY, or DUTY -= min(STEP_eff, DUTY-TGT) when TGT<DUTY, with no overflow or underflow.
REQ-021 SHALL pulse DUTY_LD on the same edge DUTY is written, and never pulse it otherwise except on FAULT entry (REQ-025).
REQ-022 SHALL, after a step where DUTY=TGT: go to HOLD if TGT!=0, or to IDLE if TGT=0.
REQ-023 SHALL not step on the IDLE->RAMP transition edge; the first step occurs on a later qualifying PERIOD_E.
REQ-024 SHALL, in HOLD, go to RAMP with div_cnt=0 on the edge where TGT!=DUTY; DUTY is unchanged on that edge.
REQ-025 SHALL, when FAULT_IN=1 in any non-FAULT state, set DUTY=0, DUTY_LD=1, div_cnt=0 and STATE=FAULT on the next edge, overriding PERIOD_E.
REQ-026 SHALL remain in FAULT while FAULT_IN=1, ignoring FAULT_CLR and PERIOD_E, and go to IDLE on the first edge with FAULT_CLR=1 and FAULT_IN=0.
REQ-027 SHALL use TGT as sampled on the stepping edge when TARGET or EN changes mid-ramp; the ramp direction reverses on the next step if needed.
REQ-028 SHALL ignore PERIOD_E in IDLE, HOLD and FAULT; a PERIOD_E coinciding with a state-entry edge is not counted.
REQ-029 SHALL latch DUTY; while RAMP waits on a step, DUTY is held.
REQ-030 SHALL drive all outputs from registers or decode of the state register only, with no combinational path from inputs.

Reset
REQ-031 SHALL, while RST=1 and without needing CLK: STATE=IDLE, DUTY=0, DUTY_LD=0, AT_TARGET=0, FAULT=0, div_cnt=0.
REQ-032 SHALL abandon any ramp or fault in progress when RST is asserted; after release the block starts from IDLE.

Verification
REQ-033 SHALL cover: EN=1, TARGET=10, STEP=3, DIV=0, PERIOD_E every 128 CLK -> DUTY 3, 6, 9, 10 on successive PERIOD_E, DUTY_LD pulse on each, then HOLD with AT_TARGET=1.
REQ-034 SHALL cover: same setup with DIV=2 -> DUTY changes only on every 3rd PERIOD_E (3, 6, 9, 10 after 3, 6, 9, 12 pulses).
REQ-035 SHALL cover: in HOLD at 10, EN=0, STEP=4 -> DUTY 6, 2, 0 on steps, then STATE=IDLE and AT_TARGET=0.
REQ-036 SHALL cover: FAULT_IN=1 at DUTY=6 mid-ramp -> next edge DUTY=0, DUTY_LD=1, STATE=11; FAULT_CLR while FAULT_IN=1 does nothing; FAULT_CLR=1 with FAULT_IN=0 -> IDLE, and the ramp restarts from 0.
REQ-037 SHALL cover: STEP=0, TARGET=2 -> DUTY 1, then 2; also RST pulse between CLK edges at DUTY=5 -> DUTY=0 and STATE=IDLE immediately.

Source files
------------

// File: rtl/pwm_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pwm_ramp_ctrl
// Purpose  : Soft-start / soft-stop duty ramp controller feeding a PWM
//            compare register. Duty moves toward the effective target by
//            STEP per ramp step, one step every DIV+1 PWM periods. A
//            level-sensitive fault forces duty to zero until acknowledged.
// Ports    : CLK, RST (async, active-high)
//            EN, TARGET[W], STEP[3], DIV[DIVW], PERIOD_E, FAULT_IN, FAULT_CLR
//            DUTY[W], DUTY_LD, AT_TARGET, STATE[2], FAULT
// Revision : 1.0 - initial release
// ============================================================================
module pwm_ramp_ctrl #(
  parameter int W    = 7,
  parameter int DIVW = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            EN,
  input  logic [W-1:0]    TARGET,
  input  logic [2:0]      STEP,
  input  logic [DIVW-1:0] DIV,
  input  logic            PERIOD_E,
  input  logic            FAULT_IN,
  input  logic            FAULT_CLR,
  output logic [W-1:0]    DUTY,
  output logic            DUTY_LD,
  output logic            AT_TARGET,
  output logic [1:0]      STATE,
  output logic            FAULT
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RAMP  = 2'b01,
    ST_HOLD  = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    duty_q, duty_d;
  logic            duty_ld_q, duty_ld_d;
  logic [DIVW-1:0] div_cnt_q, div_cnt_d;

  logic [W-1:0]    tgt;
  logic [W-1:0]    step_eff;
  logic [W-1:0]    up_diff;
  logic [W-1:0]    dn_diff;
  logic [W-1:0]    stepped_duty;

  // Effective target: a dropped EN means "ramp down to zero".
  assign tgt      = EN ? TARGET : '0;
  assign step_eff = (STEP == 3'd0) ? W'(1) : W'(STEP);
  assign up_diff  = tgt - duty_q;
  assign dn_diff  = duty_q - tgt;

  // Step is clamped to the remaining distance, so duty can never overshoot,
  // wrap past full scale or underflow below zero.
  always_comb begin
    stepped_duty = duty_q;
    if (tgt > duty_q) begin
      stepped_duty = duty_q + ((up_diff < step_eff) ? up_diff : step_eff);
    end else if (tgt < duty_q) begin
      stepped_duty = duty_q - ((dn_diff < step_eff) ? dn_diff : step_eff);
    end
  end

  always_comb begin
    state_d   = state_q;
    duty_d    = duty_q;
    duty_ld_d = 1'b0;
    div_cnt_d = div_cnt_q;

    if (FAULT_IN && (state_q != ST_FAULT)) begin
      // Fault entry wins over everything, including a coincident PERIOD_E.
      state_d   = ST_FAULT;
      duty_d    = '0;
      duty_ld_d = 1'b1;
      div_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Entry edge never steps; the first step waits for a later period.
          if (tgt != '0) begin
            state_d   = ST_RAMP;
            div_cnt_d = '0;
          end
        end
        ST_RAMP: begin
          if (PERIOD_E) begin
            if (div_cnt_q < DIV) begin
              div_cnt_d = div_cnt_q + DIVW'(1);
            end else begin
              div_cnt_d = '0;
              duty_d    = stepped_duty;
              duty_ld_d = (stepped_duty != duty_q);
              if (stepped_duty == tgt) begin
                state_d = (tgt != '0) ? ST_HOLD : ST_IDLE;
              end
            end
          end
        end
        ST_HOLD: begin
          if (tgt != duty_q) begin
            state_d   = ST_RAMP;
            div_cnt_d = '0;
          end
        end
        ST_FAULT: begin
          // Still-asserted FAULT_IN keeps us here regardless of FAULT_CLR.
          if (FAULT_CLR && !FAULT_IN) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      duty_q    <= '0;
      duty_ld_q <= 1'b0;
      div_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      duty_q    <= duty_d;
      duty_ld_q <= duty_ld_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  assign DUTY      = duty_q;
  assign DUTY_LD   = duty_ld_q;
  assign STATE     = state_q;
  assign AT_TARGET = (state_q == ST_HOLD);
  assign FAULT     = (state_q == ST_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_pwm_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_ramp_ctrl
// Purpose  : Directed self-checking bench for pwm_ramp_ctrl. Expected duty
//            values are queued when a stepping PERIOD_E is driven and popped
//            whenever DUTY_LD is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_ramp_ctrl;

  localparam int W    = 7;
  localparam int DIVW = 4;

  logic            CLK = 1'b0;
  logic            RST;
  logic            EN;
  logic [W-1:0]    TARGET;
  logic [2:0]      STEP;
  logic [DIVW-1:0] DIV;
  logic            PERIOD_E;
  logic            FAULT_IN;
  logic            FAULT_CLR;
  logic [W-1:0]    DUTY;
  logic            DUTY_LD;
  logic            AT_TARGET;
  logic [1:0]      STATE;
  logic            FAULT;

  int vectors     = 0;
  int miscompares = 0;
  logic [W-1:0] sb_q[$];

  always #5 CLK = ~CLK;

  pwm_ramp_ctrl #(.W(W), .DIVW(DIVW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .EN        (EN),
    .TARGET    (TARGET),
    .STEP      (STEP),
    .DIV       (DIV),
    .PERIOD_E  (PERIOD_E),
    .FAULT_IN  (FAULT_IN),
    .FAULT_CLR (FAULT_CLR),
    .DUTY      (DUTY),
    .DUTY_LD   (DUTY_LD),
    .AT_TARGET (AT_TARGET),
    .STATE     (STATE),
    .FAULT     (FAULT)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every DUTY_LD must consume exactly one queued expectation.
  task automatic sb_check();
    logic [W-1:0] e;
    if (DUTY_LD === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_duty_ld", 32'(DUTY), 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        chk("duty_on_ld", 32'(DUTY), 32'(e));
      end
    end
  endtask

  task automatic cyc(input logic pe);
    PERIOD_E = pe;
    @(posedge CLK);
    #1;
    PERIOD_E = 1'b0;
    sb_check();
  endtask

  // One PWM period of 128 CLK ending in a PERIOD_E pulse.
  task automatic period(input logic stp, input logic [W-1:0] exp);
    repeat (127) cyc(1'b0);
    if (stp) sb_q.push_back(exp);
    cyc(1'b1);
  endtask

  task automatic drain(input string tag);
    chk(tag, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  task automatic do_reset();
    #2 RST = 1'b1;
    #1;
    chk("rst_state", 32'(STATE), 32'd0);
    chk("rst_duty", 32'(DUTY), 32'd0);
    @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1; EN = 1'b0; TARGET = '0; STEP = 3'd0; DIV = '0;
    PERIOD_E = 1'b0; FAULT_IN = 1'b0; FAULT_CLR = 1'b0;
    #1;
    // Reset values without any clock edge.
    chk("rst_state", 32'(STATE), 32'd0);
    chk("rst_duty", 32'(DUTY), 32'd0);
    chk("rst_ld", 32'(DUTY_LD), 32'd0);
    chk("rst_at_target", 32'(AT_TARGET), 32'd0);
    chk("rst_fault", 32'(FAULT), 32'd0);
    @(posedge CLK); #1 RST = 1'b0;

    // Ramp up 0 -> 10, STEP=3, DIV=0.
    EN = 1'b1; TARGET = 7'd10; STEP = 3'd3; DIV = 4'd0;
    cyc(1'b0);
    chk("idle_to_ramp", 32'(STATE), 32'd1);
    chk("no_step_on_entry", 32'(DUTY), 32'd0);
    period(1'b1, 7'd3);
    period(1'b1, 7'd6);
    period(1'b1, 7'd9);
    period(1'b1, 7'd10);
    chk("hold_state", 32'(STATE), 32'd2);
    chk("hold_at_target", 32'(AT_TARGET), 32'd1);
    period(1'b0, 7'd0);
    chk("hold_ignores_pe", 32'(DUTY), 32'd10);
    drain("sb_up");

    // Ramp down from HOLD at 10: EN=0, STEP=4.
    EN = 1'b0; STEP = 3'd4;
    cyc(1'b0);
    chk("hold_to_ramp", 32'(STATE), 32'd1);
    chk("hold_exit_duty", 32'(DUTY), 32'd10);
    period(1'b1, 7'd6);
    period(1'b1, 7'd2);
    period(1'b1, 7'd0);
    chk("down_idle", 32'(STATE), 32'd0);
    chk("down_at_target", 32'(AT_TARGET), 32'd0);
    drain("sb_down");

    // DIV=2: step on every 3rd period.
    EN = 1'b1; TARGET = 7'd10; STEP = 3'd3; DIV = 4'd2;
    cyc(1'b0);
    for (int i = 1; i <= 12; i++) begin
      period((i % 3) == 0, 7'((i / 3) * 3 > 10 ? 10 : (i / 3) * 3));
      if ((i % 3) != 0) chk("div_hold_duty", 32'(DUTY), 32'((i / 3) * 3));
    end
    chk("div_hold_state", 32'(STATE), 32'd2);
    drain("sb_div");

    // Fault at DUTY=6 mid-ramp.
    do_reset();
    EN = 1'b1; TARGET = 7'd20; STEP = 3'd3; DIV = 4'd0;
    cyc(1'b0);
    period(1'b1, 7'd3);
    period(1'b1, 7'd6);
    FAULT_IN = 1'b1;
    sb_q.push_back(7'd0);
    cyc(1'b1);
    chk("fault_state", 32'(STATE), 32'd3);
    chk("fault_flag", 32'(FAULT), 32'd1);
    chk("fault_ld", 32'(DUTY_LD), 32'd1);
    FAULT_CLR = 1'b1;
    cyc(1'b1);
    chk("fault_clr_ignored", 32'(STATE), 32'd3);
    FAULT_IN = 1'b0;
    cyc(1'b0);
    chk("fault_to_idle", 32'(STATE), 32'd0);
    FAULT_CLR = 1'b0;
    cyc(1'b0);
    chk("restart_ramp", 32'(STATE), 32'd1);
    period(1'b1, 7'd3);
    drain("sb_fault");

    // STEP=0 acts as 1.
    do_reset();
    EN = 1'b1; TARGET = 7'd2; STEP = 3'd0; DIV = 4'd0;
    cyc(1'b0);
    period(1'b1, 7'd1);
    period(1'b1, 7'd2);
    chk("step0_hold", 32'(STATE), 32'd2);

    // Async reset between edges at DUTY=5.
    TARGET = 7'd9; STEP = 3'd3;
    cyc(1'b0);
    period(1'b1, 7'd5);
    chk("pre_rst_duty", 32'(DUTY), 32'd5);
    #2 RST = 1'b1;
    #1;
    chk("async_rst_duty", 32'(DUTY), 32'd0);
    chk("async_rst_state", 32'(STATE), 32'd0);
    chk("async_rst_ld", 32'(DUTY_LD), 32'd0);
    @(posedge CLK); #1 RST = 1'b0;
    drain("sb_step0");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
